sdram_uart_cmd: RTL



---
 rtl/sdram_uart_cmd.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_uart_cmd.sv
`default_nettype none
// =============================================================================
// Module : sdram_uart_cmd
// Brief  : 8N1 UART command frames -> single-word SDRAM write/read requests,
//          read data returned on a valid/ready response port.
//          Optional frame gap timeout: define SDRAM_CMD_TIMEOUT_EN.
// Rev    : 1.0  initial release
// =============================================================================
module sdram_uart_cmd #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_ad,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_granted,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_ad,
  input  logic                  rd_granted,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_rdy,
  output logic                  err
);

  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] c_rx_idle  = 2'd0;
  localparam logic [1:0] c_rx_start = 2'd1;
  localparam logic [1:0] c_rx_data  = 2'd2;
  localparam logic [1:0] c_rx_stop  = 2'd3;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_addr = 3'd1;
  localparam logic [2:0] c_st_data = 3'd2;
  localparam logic [2:0] c_st_wr   = 3'd3;
  localparam logic [2:0] c_st_rd   = 3'd4;
  localparam logic [2:0] c_st_rdw  = 3'd5;
  localparam logic [2:0] c_st_rsp  = 3'd6;

  localparam logic [7:0] c_op_wr = 8'h57;
  localparam logic [7:0] c_op_rd = 8'h52;

  // RX front end
  logic               rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]         rx_state_q, rx_state_d;
  logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               w_start_edge, w_half_tick, w_bit_tick;
  logic               w_byte_vld, w_frame_err;

  // Frame parser
  logic [2:0]            st_q, st_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  err_q, err_d;
  logic                  w_op_ok, w_byte_err, w_timeout;

  assign w_start_edge = rx_prev_q & ~rx_s2_q;
  assign w_half_tick  = (rx_state_q == c_rx_start) && (rx_cnt_q == c_half_last);
  assign w_bit_tick   = (rx_cnt_q == c_bit_last);

  always_comb begin : rx_next
    rx_state_d = rx_state_q;
    case (rx_state_q)
      c_rx_idle:  if (w_start_edge) rx_state_d = c_rx_start;
      c_rx_start: if (w_half_tick) rx_state_d = rx_s2_q ? c_rx_idle : c_rx_data;
      c_rx_data:  if (w_bit_tick && bit_idx_q == 3'd7) rx_state_d = c_rx_stop;
      c_rx_stop:  if (w_bit_tick) rx_state_d = c_rx_idle;
      default:    rx_state_d = c_rx_idle;
    endcase
  end

  always_comb begin : rx_out
    rx_cnt_d    = rx_cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    w_byte_vld  = 1'b0;
    w_frame_err = 1'b0;
    case (rx_state_q)
      c_rx_idle: begin
        rx_cnt_d  = '0;
        bit_idx_d = 3'd0;
      end
      c_rx_start: if (w_half_tick) rx_cnt_d = '0;
      c_rx_data: if (w_bit_tick) begin
        rx_cnt_d  = '0;
        shift_d   = {rx_s2_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end
      c_rx_stop: if (w_bit_tick) begin
        w_byte_vld  = rx_s2_q;
        w_frame_err = ~rx_s2_q;
      end
      default: rx_cnt_d = '0;
    endcase
  end

`ifdef SDRAM_CMD_TIMEOUT_EN
  localparam int                to_w      = $clog2(16 * CLKS_PER_BIT);
  localparam logic [to_w-1:0]   c_to_last = to_w'(16 * CLKS_PER_BIT - 1);
  logic [to_w-1:0] to_cnt_q, to_cnt_d;

  // Measures time since the last start edge; saturates so an idle line stays "expired".
  assign to_cnt_d  = w_start_edge ? '0 : ((to_cnt_q == c_to_last) ? to_cnt_q : to_cnt_q + 1'b1);
  assign w_timeout = (st_q == c_st_addr || st_q == c_st_data) && (to_cnt_q == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_op_ok    = (shift_q == c_op_wr) || (shift_q == c_op_rd);
  assign w_byte_err = w_byte_vld &&
                      ((st_q == c_st_idle && !w_op_ok) ||
                       (st_q inside {c_st_wr, c_st_rd, c_st_rdw, c_st_rsp}));

  always_comb begin : parse_next
    st_d = st_q;
    case (st_q)
      c_st_idle: if (w_byte_vld && w_op_ok) st_d = c_st_addr;
      c_st_addr: begin
        if (w_frame_err || w_timeout)              st_d = c_st_idle;
        else if (w_byte_vld && byte_cnt_q == 2'd2) st_d = is_wr_q ? c_st_data : c_st_rd;
      end
      c_st_data: begin
        if (w_frame_err || w_timeout)              st_d = c_st_idle;
        else if (w_byte_vld && byte_cnt_q == 2'd3) st_d = c_st_wr;
      end
      c_st_wr:  if (wr_granted) st_d = c_st_idle;
      c_st_rd:  if (rd_granted) st_d = rd_valid ? c_st_rsp : c_st_rdw;
      c_st_rdw: if (rd_valid) st_d = c_st_rsp;
      c_st_rsp: if (rsp_rdy) st_d = c_st_idle;
      default:  st_d = c_st_idle;
    endcase
  end

  always_comb begin : parse_out
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    case (st_q)
      c_st_idle: if (w_byte_vld && w_op_ok) begin
        is_wr_d    = (shift_q == c_op_wr);
        byte_cnt_d = 2'd0;
        addr_d     = '0;
      end
      c_st_addr: if (w_byte_vld && !w_frame_err) begin
        addr_d     = {addr_q[ADDR_WIDTH-9:0], shift_q};
        byte_cnt_d = (byte_cnt_q == 2'd2) ? 2'd0 : byte_cnt_q + 2'd1;
      end
      c_st_data: if (w_byte_vld) begin
        data_d     = {data_q[DATA_WIDTH-9:0], shift_q};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
      c_st_rd:  if (rd_granted && rd_valid) rsp_data_d = rd_data;
      c_st_rdw: if (rd_valid) rsp_data_d = rd_data;
      default: ;
    endcase
    wr_req_d    = (st_d == c_st_wr);
    rd_req_d    = (st_d == c_st_rd);
    rsp_valid_d = (st_d == c_st_rsp);
    err_d       = w_frame_err | w_byte_err | w_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= c_rx_idle;
      rx_cnt_q    <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      st_q        <= c_st_idle;
      byte_cnt_q  <= 2'd0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      st_q        <= st_d;
      byte_cnt_q  <= byte_cnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign wr_req    = wr_req_q;
  assign wr_ad     = addr_q;
  assign wr_data   = data_q;
  assign rd_req    = rd_req_q;
  assign rd_ad     = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule
`default_nettype wire
